// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with a 2-FF line synchroniser, centre-of-bit
//             sampling and a valid/ready holding register. Optional even
//             parity bit when UART_RX_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit RX_INV       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  HALF_M1   = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]  FULL_M1   = BW'(CLKS_PER_BIT - 1);
  localparam logic           SYNC_IDLE = RX_INV ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state, state_n;
  logic            sync1, sync2;
  logic            line;
  logic [BW-1:0]   bcnt;
  logic [2:0]      bidx;
  logic [7:0]      sh;
  logic            deliver;

  logic            bcnt_clr;
  logic            shift_en;
  logic            par_en;
  logic            stop_ok;
  logic            stop_bad;

  assign line    = sync2 ^ RX_INV;
  assign rx_busy = (state != S_IDLE);
  assign overrun = deliver & rx_valid & ~rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bcnt_clr = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE: begin
        bcnt_clr = 1'b1;
        if (!line) state_n = S_START;
      end
      S_START: begin
        if (bcnt == HALF_M1) begin
          bcnt_clr = 1'b1;
          state_n  = line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bcnt == FULL_M1) begin
          bcnt_clr = 1'b1;
          shift_en = 1'b1;
          if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bcnt == FULL_M1) begin
          bcnt_clr = 1'b1;
          par_en   = 1'b1;
          state_n  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bcnt == FULL_M1) begin
          bcnt_clr = 1'b1;
          if (line) begin
            stop_ok = 1'b1;
            state_n = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        bcnt_clr = 1'b1;
        if (line) state_n = S_IDLE;
      end
      default: begin
        bcnt_clr = 1'b1;
        state_n  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt      <= '0;
      bidx      <= 3'd0;
      sh        <= 8'h00;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bcnt      <= bcnt_clr ? '0 : bcnt + BW'(1);
      if (shift_en) begin
        sh   <= {line, sh[7:1]};
        bidx <= bidx + 3'd1;
      end else if (state != S_DATA) begin
        bidx <= 3'd0;
      end
      deliver   <= stop_ok;
      frame_err <= stop_bad;
    end
  end

  // A delivery while the holding register is being drained replaces the byte
  // in the same cycle, so rx_valid never drops between the two bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (deliver && (!rx_valid || rx_ready)) begin
      rx_data  <= sh;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_bad <= 1'b0;
    else if (par_en) par_bad <= (^sh) ^ line;
  end

  assign parity_err = deliver & par_bad;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx (CLKS_PER_BIT=16).
//             Parity scenario runs only when UART_RX_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 156 + CPB;
`else
  localparam int LAT = 156;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vr_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .RX_INV(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt = fe_cnt + 1;
    if (overrun)    ov_cnt = ov_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
    if (rx_valid && !prev_valid) begin
      vr_cnt   = vr_cnt + 1;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  task automatic drive_bit(input logic b);
    #1 rxd = b;
    repeat (CPB) @(posedge clk);
  endtask

  // Start bit falls 1 time unit after a posedge; returns on a posedge at the
  // end of the stop bit with rxd still at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    @(posedge clk);
    #1 fall_cyc = cyc;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic accept;
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    checks++; if ({frame_err, overrun, parity_err} !== 3'b000)
      begin errors++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err}); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL reset_idle_after_release: got %b expected 0", rx_busy); end
  endtask

  task automatic test_basic;
    int fe0, vr0;
    fe0 = fe_cnt; vr0 = vr_cnt;
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5)   begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    checks++; if (rise_cyc - fall_cyc !== LAT)
      begin errors++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - fall_cyc, LAT); end
    repeat (20) @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
      begin errors++; $display("FAIL basic_hold: got valid=%b data=%h expected 1/a5", rx_valid, rx_data); end
    accept();
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL basic_accept: got %b expected 0", rx_valid); end
    checks++; if (fe_cnt - fe0 !== 0 || vr_cnt - vr0 !== 1)
      begin errors++; $display("FAIL basic_counts: got fe=%0d rises=%0d expected 0/1", fe_cnt - fe0, vr_cnt - vr0); end
  endtask

  task automatic test_glitch;
    int fe0, vr0;
    fe0 = fe_cnt; vr0 = vr_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1)    begin errors++; $display("FAIL glitch_busy: got %b expected 1", rx_busy); end
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
    checks++; if (fe_cnt - fe0 !== 0 || vr_cnt - vr0 !== 0 || rx_valid !== 1'b0)
      begin errors++; $display("FAIL glitch_quiet: got fe=%0d rises=%0d valid=%b expected 0/0/0", fe_cnt - fe0, vr_cnt - vr0, rx_valid); end
  endtask

  task automatic test_frame_err;
    int fe0, vr0;
    fe0 = fe_cnt; vr0 = vr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1)  begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (vr_cnt - vr0 !== 0 || rx_valid !== 1'b0)
      begin errors++; $display("FAIL ferr_no_valid: got rises=%0d valid=%b expected 0/0", vr_cnt - vr0, rx_valid); end
    checks++; if (rx_busy !== 1'b1)    begin errors++; $display("FAIL ferr_break_busy: got %b expected 1", rx_busy); end
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL ferr_break_exit: got %b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int ov0;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11)
      begin errors++; $display("FAIL b2b_keep_old: got valid=%b data=%h expected 1/11", rx_valid, rx_data); end
    checks++; if (ov_cnt - ov0 !== 1)  begin errors++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ov_cnt - ov0); end
    accept();
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL b2b_drain: got %b expected 0", rx_valid); end

    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22)
          begin errors++; $display("FAIL b2b_swap: got valid=%b data=%h expected 1/22", rx_valid, rx_data); end
      end
    join
    repeat (5) @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22)
      begin errors++; $display("FAIL b2b_swap_hold: got valid=%b data=%h expected 1/22", rx_valid, rx_data); end
    checks++; if (ov_cnt - ov0 !== 0)  begin errors++; $display("FAIL b2b_no_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    accept();
  endtask

  task automatic test_reset_midframe;
    int fe0, ov0, pe0, vr0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; vr0 = vr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (CPB * 5 + 8) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", rx_busy); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got %b expected 0", rx_busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    send_frame(8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h0F)
      begin errors++; $display("FAIL rstmid_data: got valid=%b data=%h expected 1/0f", rx_valid, rx_data); end
    checks++; if (vr_cnt - vr0 !== 1)  begin errors++; $display("FAIL rstmid_one_byte: got %0d deliveries expected 1", vr_cnt - vr0); end
    checks++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0 || pe_cnt - pe0 !== 0)
      begin errors++; $display("FAIL rstmid_no_err: got fe=%0d ov=%0d pe=%0d expected 0/0/0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0); end
    accept();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int pe0;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07)
      begin errors++; $display("FAIL par_good_data: got valid=%b data=%h expected 1/07", rx_valid, rx_data); end
    checks++; if (pe_cnt - pe0 !== 0)  begin errors++; $display("FAIL par_good_err: got %0d pulses expected 0", pe_cnt - pe0); end
    accept();
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07)
      begin errors++; $display("FAIL par_bad_data: got valid=%b data=%h expected 1/07", rx_valid, rx_data); end
    checks++; if (pe_cnt - pe0 !== 1)  begin errors++; $display("FAIL par_bad_err: got %0d pulses expected 1", pe_cnt - pe0); end
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
